ball_controller: RTL and testbench

- Per-frame ball physics stage directly upstream of the game renderer.
- On each FRAME_DONE pulse from the renderer it advances the ball one step and reflects it off the walls, the paddle and live blocks.
- It queries and kills blocks through its own block-RAM port, and reports hits and ball loss to the score/lives logic.
- Its registered BALL_X_PIXEL/BALL_Y_PIXEL outputs drive the renderer's ball inputs.

---
 rtl/ball_controller.sv | 184 ++++++++++++++++++
 tb/tb_ball_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// Per-frame ball physics: steps the ball on each FRAME_DONE, bounces it off walls,
// paddle and live blocks, and reports block hits and ball loss.
module ball_controller #(
  parameter int unsigned SCREEN_W   = 800,
  parameter int unsigned SCREEN_H   = 600,
  parameter int unsigned BALL_SIZE  = 8,
  parameter int unsigned PADDLE_Y   = 568,
  parameter int unsigned PADDLE_W   = 64,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned BLOCK_X0   = 16,
  parameter int unsigned BLOCK_Y0   = 64,
  parameter int unsigned BLOCK_W    = 64,
  parameter int unsigned BLOCK_H    = 16,
  parameter int unsigned BLOCK_COLS = 12,
  parameter int unsigned BLOCK_ROWS = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FRAME_DONE,
  input  logic       LAUNCH,
  input  logic [9:0] PADDLE_X_PIXEL,
  output logic [6:0] BLOCK_ADDR,
  input  logic       BLOCK_ALIVE,
  output logic       BLOCK_KILL,
  output logic [9:0] BALL_X_PIXEL,
  output logic [9:0] BALL_Y_PIXEL,
  output logic       HIT,
  output logic       BALL_LOST,
  output logic       BUSY
);

  localparam int unsigned BW_SH = $clog2(BLOCK_W);
  localparam int unsigned BH_SH = $clog2(BLOCK_H);

  localparam logic signed [11:0] C_SPEED    = 12'(SPEED);
  localparam logic signed [11:0] C_BALL     = 12'(BALL_SIZE);
  localparam logic signed [11:0] C_HALF     = 12'(BALL_SIZE / 2);
  localparam logic signed [11:0] C_XMAX     = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] C_SCREEN_H = 12'(SCREEN_H);
  localparam logic signed [11:0] C_PADDLE_Y = 12'(PADDLE_Y);
  localparam logic signed [11:0] C_PADDLE_W = 12'(PADDLE_W);
  localparam logic signed [11:0] C_PHALF    = 12'(PADDLE_W / 2);
  localparam logic signed [11:0] C_BX0      = 12'(BLOCK_X0);
  localparam logic signed [11:0] C_BY0      = 12'(BLOCK_Y0);
  localparam logic signed [11:0] C_GRID_W   = 12'(BLOCK_W * BLOCK_COLS);
  localparam logic signed [11:0] C_GRID_H   = 12'(BLOCK_H * BLOCK_ROWS);

  localparam logic [9:0] RST_X = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] RST_Y = 10'(PADDLE_Y - BALL_SIZE);

  typedef enum logic [1:0] {WAIT, CALC, LOOKUP, RESOLVE} state_t;

  state_t state;
  logic   moving, launch_q;
  logic   dx_pos, dy_pos;

  logic signed [11:0] cand_x, cand_y;
  logic               cand_dx_pos, cand_dy_pos, cand_lost, cand_blk;

  logic signed [11:0] px, ox, oy, nx, ny, hx, gx, gy;
  logic               ndx_pos, ndy_pos, c_lost, c_in_grid;
  logic [6:0]         c_row, c_col, c_addr;

  // Candidate step with wall, ceiling and paddle corrections applied in order
  always_comb begin
    px      = $signed({2'b00, PADDLE_X_PIXEL});
    ox      = $signed({2'b00, BALL_X_PIXEL});
    oy      = $signed({2'b00, BALL_Y_PIXEL});
    ndx_pos = dx_pos;
    ndy_pos = dy_pos;
    nx      = dx_pos ? ox + C_SPEED : ox - C_SPEED;
    ny      = dy_pos ? oy + C_SPEED : oy - C_SPEED;
    if (nx[11]) begin
      nx      = '0;
      ndx_pos = 1'b1;
    end
    if (nx > C_XMAX) begin
      nx      = C_XMAX;
      ndx_pos = 1'b0;
    end
    if (ny[11]) begin
      ny      = '0;
      ndy_pos = 1'b1;
    end
    if (ndy_pos && (oy + C_BALL <= C_PADDLE_Y) && (ny + C_BALL >= C_PADDLE_Y) &&
        (nx + C_BALL > px) && (nx < px + C_PADDLE_W)) begin
      ny      = C_PADDLE_Y - C_BALL;
      ndy_pos = 1'b0;
    end
    c_lost    = (ny >= C_SCREEN_H);
    gx        = nx + C_HALF - C_BX0;
    gy        = ny + C_HALF - C_BY0;
    c_in_grid = !c_lost && !gx[11] && (gx < C_GRID_W) && !gy[11] && (gy < C_GRID_H);
    c_col     = 7'(gx >>> BW_SH);
    c_row     = 7'(gy >>> BH_SH);
    c_addr    = c_row * 7'(BLOCK_COLS) + c_col;
    hx        = px + C_PHALF - C_HALF;
    if (hx > C_XMAX) hx = C_XMAX;
    if (hx[11])      hx = '0;
  end

  // Frame sequencer: WAIT -> CALC -> LOOKUP -> RESOLVE, commit on the RESOLVE edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= WAIT;
      moving       <= 1'b0;
      launch_q     <= 1'b0;
      dx_pos       <= 1'b1;
      dy_pos       <= 1'b0;
      BALL_X_PIXEL <= RST_X;
      BALL_Y_PIXEL <= RST_Y;
      BLOCK_ADDR   <= '0;
      BLOCK_KILL   <= 1'b0;
      HIT          <= 1'b0;
      BALL_LOST    <= 1'b0;
      BUSY         <= 1'b0;
      cand_x       <= '0;
      cand_y       <= '0;
      cand_dx_pos  <= 1'b1;
      cand_dy_pos  <= 1'b0;
      cand_lost    <= 1'b0;
      cand_blk     <= 1'b0;
    end else begin
      BLOCK_KILL <= 1'b0;
      HIT        <= 1'b0;
      BALL_LOST  <= 1'b0;
      unique case (state)
        WAIT: begin
          if (FRAME_DONE) begin
            state    <= CALC;
            BUSY     <= 1'b1;
            launch_q <= LAUNCH;
          end
        end
        CALC: begin
          state <= LOOKUP;
          if (moving) begin
            cand_x      <= nx;
            cand_y      <= ny;
            cand_dx_pos <= ndx_pos;
            cand_dy_pos <= ndy_pos;
            cand_lost   <= c_lost;
            cand_blk    <= c_in_grid;
            if (c_in_grid) BLOCK_ADDR <= c_addr;
          end else begin
            // Held ball rides the paddle; no lookup, direction untouched
            cand_x      <= hx;
            cand_y      <= C_PADDLE_Y - C_BALL;
            cand_dx_pos <= dx_pos;
            cand_dy_pos <= dy_pos;
            cand_lost   <= 1'b0;
            cand_blk    <= 1'b0;
          end
        end
        LOOKUP: state <= RESOLVE;
        RESOLVE: begin
          state        <= WAIT;
          BUSY         <= 1'b0;
          BALL_X_PIXEL <= 10'(cand_x);
          if (cand_lost) begin
            BALL_LOST    <= 1'b1;
            moving       <= 1'b0;
            dx_pos       <= 1'b1;
            dy_pos       <= 1'b0;
            BALL_Y_PIXEL <= 10'(cand_y);
          end else if (cand_blk && BLOCK_ALIVE) begin
            // Bounce back: keep the old y, flip vertical direction
            BLOCK_KILL <= 1'b1;
            HIT        <= 1'b1;
            dx_pos     <= cand_dx_pos;
            dy_pos     <= !cand_dy_pos;
          end else begin
            BALL_Y_PIXEL <= 10'(cand_y);
            dx_pos       <= cand_dx_pos;
            dy_pos       <= cand_dy_pos;
          end
          if (!moving && launch_q) moving <= 1'b1;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_controller.sv
// Randomized bench for ball_controller: a game-level reference model queues the
// expected commit of each frame; a monitor checks the DUT at each commit.
module tb_ball_controller;

  localparam int SW = 800, SH = 600, BS = 8, PY = 568, PW = 64, SP = 4;
  localparam int BX0 = 16, BY0 = 64, BW = 64, BH = 16, COLS = 12, ROWS = 8;
  localparam int NFRAMES = 2500;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       FRAME_DONE = 1'b0;
  logic       LAUNCH = 1'b0;
  logic [9:0] PADDLE_X_PIXEL = '0;
  logic [6:0] BLOCK_ADDR;
  logic       BLOCK_ALIVE = 1'b0;
  logic       BLOCK_KILL;
  logic [9:0] BALL_X_PIXEL, BALL_Y_PIXEL;
  logic       HIT, BALL_LOST, BUSY;

  ball_controller dut (
    .CLK(CLK), .RESET(RESET), .FRAME_DONE(FRAME_DONE), .LAUNCH(LAUNCH),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BLOCK_ADDR(BLOCK_ADDR), .BLOCK_ALIVE(BLOCK_ALIVE),
    .BLOCK_KILL(BLOCK_KILL), .BALL_X_PIXEL(BALL_X_PIXEL), .BALL_Y_PIXEL(BALL_Y_PIXEL),
    .HIT(HIT), .BALL_LOST(BALL_LOST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int x, y, addr;
    bit hit, lost, kill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;

  // Block RAM seen by the DUT, one-cycle read latency
  bit ram [0:127];
  bit ref_alive [0:127];
  always @(posedge CLK) begin
    BLOCK_ALIVE <= ram[BLOCK_ADDR];
    if (BLOCK_KILL) ram[BLOCK_ADDR] <= 1'b0;
  end

  // Reference game state
  bit m_moving;
  int m_x, m_y, m_dx, m_dy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_moving = 1'b0;
    m_x = SW / 2 - BS / 2;
    m_y = PY - BS;
    m_dx = SP;
    m_dy = -SP;
  endtask

  task automatic model_frame(input int px, input bit la, output exp_t e);
    int nx, ny, ndx, ndy, cx, cy, idx;
    e = '{x: 0, y: 0, addr: 0, hit: 1'b0, lost: 1'b0, kill: 1'b0};
    if (!m_moving) begin
      nx = px + PW / 2 - BS / 2;
      if (nx > SW - BS) nx = SW - BS;
      if (nx < 0) nx = 0;
      m_x = nx;
      m_y = PY - BS;
      if (la) m_moving = 1'b1;
    end else begin
      nx = m_x + m_dx; ny = m_y + m_dy; ndx = m_dx; ndy = m_dy;
      if (nx < 0)       begin nx = 0;       ndx = SP;  end
      if (nx > SW - BS) begin nx = SW - BS; ndx = -SP; end
      if (ny < 0)       begin ny = 0;       ndy = SP;  end
      if (ndy > 0 && m_y + BS <= PY && ny + BS >= PY && nx + BS > px && nx < px + PW) begin
        ny = PY - BS;
        ndy = -SP;
      end
      if (ny >= SH) begin
        e.lost = 1'b1;
        m_moving = 1'b0;
        m_x = nx; m_y = ny; m_dx = SP; m_dy = -SP;
      end else begin
        cx = nx + BS / 2;
        cy = ny + BS / 2;
        if (cx >= BX0 && cx < BX0 + BW * COLS && cy >= BY0 && cy < BY0 + BH * ROWS) begin
          idx = ((cy - BY0) / BH) * COLS + (cx - BX0) / BW;
          if (ref_alive[idx]) begin
            e.kill = 1'b1; e.hit = 1'b1; e.addr = idx;
            ref_alive[idx] = 1'b0;
            ny = m_y;
            ndy = -ndy;
          end
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      end
    end
    e.x = m_x;
    e.y = m_y;
  endtask

  // Monitor: compare at each commit, and flag pulses anywhere else
  bit   busy_prev = 1'b0;
  int   busy_cnt = 0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (RESET) begin
      busy_prev = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy_prev && !BUSY) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ball_x", int'(BALL_X_PIXEL), mon_e.x);
          chk("ball_y", int'(BALL_Y_PIXEL), mon_e.y);
          chk("hit", int'(HIT), int'(mon_e.hit));
          chk("kill", int'(BLOCK_KILL), int'(mon_e.kill));
          chk("ball_lost", int'(BALL_LOST), int'(mon_e.lost));
          if (mon_e.kill) chk("block_addr", int'(BLOCK_ADDR), mon_e.addr);
        end
        chk("busy_cycles", busy_cnt, 3);
        busy_cnt = 0;
      end else begin
        chk("stray_pulse", int'({HIT, BLOCK_KILL, BALL_LOST}), 0);
      end
      if (BUSY) busy_cnt++;
      busy_prev = BUSY;
    end
  end

  task automatic check_reset_values();
    chk("rst_ball_x", int'(BALL_X_PIXEL), SW / 2 - BS / 2);
    chk("rst_ball_y", int'(BALL_Y_PIXEL), PY - BS);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_addr", int'(BLOCK_ADDR), 0);
    chk("rst_pulses", int'({HIT, BLOCK_KILL, BALL_LOST}), 0);
  endtask

  task automatic do_frame(input int px, input bit la, input bit extra, input bit rst_mid);
    exp_t e;
    int   n;
    @(posedge CLK); #1;
    PADDLE_X_PIXEL = 10'(px);
    LAUNCH = la;
    FRAME_DONE = 1'b1;
    model_frame(px, la, e);
    sb.push_back(e);
    @(posedge CLK); #1;            // edge k taken
    FRAME_DONE = extra;
    LAUNCH = 1'($urandom);
    @(posedge CLK); #1;            // edge k+1 taken
    FRAME_DONE = 1'b0;
    if (rst_mid) begin
      @(posedge CLK); #1;          // edge k+2 taken, now in RESOLVE
      RESET = 1'b1;
      sb.delete();
      model_reset();
      #1;
      check_reset_values();
      @(posedge CLK); #1;
      RESET = 1'b0;
    end else begin
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(posedge CLK);
        n++;
      end
      #1;
      chk("commit_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat ($urandom_range(0, 3)) @(posedge CLK);
  endtask

  initial begin
    int px;
    for (int i = 0; i < 128; i++) begin
      ram[i] = (i < COLS * ROWS) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ref_alive[i] = ram[i];
    end
    model_reset();
    #2 RESET = 1'b1;
    #3 check_reset_values();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    for (int f = 0; f < 10; f++) do_frame(100, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < NFRAMES; f++) begin
      if (m_moving && $urandom_range(0, 99) < 88) begin
        px = m_x + m_dx - int'($urandom_range(0, 55));
        if (px < 0) px = 0;
      end else begin
        px = int'($urandom_range(0, 1023));
      end
      do_frame(px, ($urandom_range(0, 99) < 30), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 99) < 2));
    end

    repeat (5) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
